// File: rtl/radio_pll_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : radio_pll_seq_pkg
//  Description : Shared types and constants for the radio PLL hop sequencer.
//                Holds the sequencer state encoding, the channel count and a
//                helper that tells whether a state presents a locked PLL.
//  Revision    : 1.0  initial release
// ============================================================================
package radio_pll_seq_pkg;

    // Number of hop channels (0..78).
    localparam int NUM_CH = 79;

    // Width of a channel index.
    localparam int FK_W = $clog2(NUM_CH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_READY  = 3'd2,
        ST_TX     = 3'd3,
        ST_RX     = 3'd4
    } pll_state_t;

    // READY, TX and RX all run with a settled synthesizer.
    function automatic logic is_locked_state(input pll_state_t s);
        return (s == ST_READY) || (s == ST_TX) || (s == ST_RX);
    endfunction

endpackage : radio_pll_seq_pkg
`default_nettype wire

// File: rtl/radio_pll_seq_us_downcounter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : radio_pll_seq_us_downcounter
//  Description : Microsecond down-counter. Loads a start value, decrements on
//                each tick while nonzero (never wraps) and reports completion.
//  Ports       : clk       - clock
//                rstz      - asynchronous active-low reset
//                load      - load load_val (wins over tick)
//                load_val  - start value
//                tick      - decrement enable (1 us pulse)
//                done      - EARLY=0: count is zero
//                            EARLY=1: the final decrement happens this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module radio_pll_seq_us_downcounter #(
    parameter int W     = 10,
    parameter bit EARLY = 1'b0
) (
    input  logic         clk,
    input  logic         rstz,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    generate
        if (EARLY) begin : g_early
            // Flag the edge on which the count reaches zero, so the consumer
            // can act on that same edge.
            assign done = tick && (r_count == W'(1));
        end else begin : g_zero
            assign done = (r_count == '0);
        end
    endgenerate

endmodule : radio_pll_seq_us_downcounter
`default_nettype wire

// File: rtl/radio_pll_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : radio_pll_seq
//  Description : Hop sequencer between the link controller and the radio.
//                Latches the next channel on fk_chg_p, strobes the synthesizer
//                load, times PLL settling in microseconds and only then grants
//                the PA/LNA enables. Powers the PLL down after IDLE_US of
//                unused lock.
//  Ports       : clk_6M            - 6 MHz baseband clock
//                rstz              - asynchronous active-low reset
//                p_1us             - 1 us pulse
//                regi_pllsetuptime - settle time in us, sampled at each load
//                nxtfk             - next hop channel
//                fk_chg_p          - channel-change request
//                txbit_period      - TX window request
//                rxbit_period      - RX window request
//                radio_fk          - channel presented to the radio
//                loadfreq_p        - synthesizer load strobe
//                pll_en            - synthesizer power enable
//                pll_locked        - high in READY/TX/RX
//                pa_en / lna_en    - TX / RX front-end enables
//                late_p            - request seen while not locked
//  Revision    : 1.0  initial release
// ============================================================================
module radio_pll_seq
    import radio_pll_seq_pkg::*;
#(
    parameter int IDLE_US = 100,
    parameter int CNT_W   = 10
) (
    input  logic            clk_6M,
    input  logic            rstz,
    input  logic            p_1us,
    input  logic [9:0]      regi_pllsetuptime,
    input  logic [FK_W-1:0] nxtfk,
    input  logic            fk_chg_p,
    input  logic            txbit_period,
    input  logic            rxbit_period,
    output logic [FK_W-1:0] radio_fk,
    output logic            loadfreq_p,
    output logic            pll_en,
    output logic            pll_locked,
    output logic            pa_en,
    output logic            lna_en,
    output logic            late_p
);

    localparam int IDLE_W = $clog2(IDLE_US + 1);

    pll_state_t      r_state;
    pll_state_t      w_next;
    logic            w_req;
    logic            w_late;
    logic            w_settle_done;
    logic            w_idle_done;
    logic            w_idle_load;
    logic            w_idle_tick;

    logic [FK_W-1:0] r_radio_fk;
    logic            r_loadfreq_p;
    logic            r_pll_en;
    logic            r_pll_locked;
    logic            r_pa_en;
    logic            r_lna_en;
    logic            r_late_p;
    logic            r_late_flag;

    assign w_req = txbit_period || rxbit_period;

    // Settle timer: reloaded by every channel change.
    radio_pll_seq_us_downcounter #(
        .W     (CNT_W),
        .EARLY (1'b0)
    ) u_settle_cnt (
        .clk      (clk_6M),
        .rstz     (rstz),
        .load     (fk_chg_p),
        .load_val (CNT_W'(regi_pllsetuptime)),
        .tick     (p_1us),
        .done     (w_settle_done)
    );

    // Idle timer: held at IDLE_US outside READY or while a request is up, so
    // only uninterrupted READY microseconds run it down.
    assign w_idle_load = (r_state != ST_READY) || w_req;
    assign w_idle_tick = p_1us && (r_state == ST_READY);

    radio_pll_seq_us_downcounter #(
        .W     (IDLE_W),
        .EARLY (1'b1)
    ) u_idle_cnt (
        .clk      (clk_6M),
        .rstz     (rstz),
        .load     (w_idle_load),
        .load_val (IDLE_W'(IDLE_US)),
        .tick     (w_idle_tick),
        .done     (w_idle_done)
    );

    // State register
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a channel change overrides everything else.
    always_comb begin
        w_next = r_state;
        w_late = 1'b0;
        if ((r_state == ST_IDLE) || (r_state == ST_SETTLE)) begin
            w_late = w_req && !r_late_flag;
        end
        if (fk_chg_p) begin
            w_next = ST_SETTLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next = ST_IDLE;
                end
                ST_SETTLE: begin
                    if (w_settle_done) begin
                        w_next = ST_READY;
                    end
                end
                ST_READY: begin
                    if (txbit_period) begin
                        w_next = ST_TX;
                    end else if (rxbit_period) begin
                        w_next = ST_RX;
                    end else if (w_idle_done) begin
                        w_next = ST_IDLE;
                    end
                end
                ST_TX: begin
                    if (!txbit_period) begin
                        w_next = ST_READY;
                    end
                end
                ST_RX: begin
                    if (!rxbit_period) begin
                        w_next = ST_READY;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so the enables
    // change on the same edge as the state.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_radio_fk   <= '0;
            r_loadfreq_p <= 1'b0;
            r_pll_en     <= 1'b0;
            r_pll_locked <= 1'b0;
            r_pa_en      <= 1'b0;
            r_lna_en     <= 1'b0;
            r_late_p     <= 1'b0;
            r_late_flag  <= 1'b0;
        end else begin
            if (fk_chg_p) begin
                r_radio_fk <= nxtfk;
            end
            r_loadfreq_p <= fk_chg_p;
            r_pll_en     <= (w_next != ST_IDLE);
            r_pll_locked <= is_locked_state(w_next);
            r_pa_en      <= (w_next == ST_TX);
            r_lna_en     <= (w_next == ST_RX);
            r_late_p     <= w_late;
            // A channel change counts as a fresh entry into SETTLE.
            if ((w_next != r_state) || fk_chg_p) begin
                r_late_flag <= 1'b0;
            end else if (w_late) begin
                r_late_flag <= 1'b1;
            end
        end
    end

    assign radio_fk   = r_radio_fk;
    assign loadfreq_p = r_loadfreq_p;
    assign pll_en     = r_pll_en;
    assign pll_locked = r_pll_locked;
    assign pa_en      = r_pa_en;
    assign lna_en     = r_lna_en;
    assign late_p     = r_late_p;

endmodule : radio_pll_seq
`default_nettype wire

// File: tb/tb_radio_pll_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_radio_pll_seq
//  Description : Directed/randomized self-checking bench for radio_pll_seq.
//                Expected timing is derived from counted 1 us pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_radio_pll_seq;

    logic       clk_6M = 1'b0;
    logic       rstz;
    logic       p_1us;
    logic [9:0] regi_pllsetuptime;
    logic [6:0] nxtfk;
    logic       fk_chg_p;
    logic       txbit_period;
    logic       rxbit_period;
    logic [6:0] radio_fk;
    logic       loadfreq_p;
    logic       pll_en;
    logic       pll_locked;
    logic       pa_en;
    logic       lna_en;
    logic       late_p;

    int checks   = 0;
    int failures = 0;
    int n_us     = 0;    // 1 us pulses seen by the DUT at rising edges
    logic last_p = 1'b0; // p_1us value at the most recent rising edge

    radio_pll_seq #(.IDLE_US(100), .CNT_W(10)) dut (
        .clk_6M            (clk_6M),
        .rstz              (rstz),
        .p_1us             (p_1us),
        .regi_pllsetuptime (regi_pllsetuptime),
        .nxtfk             (nxtfk),
        .fk_chg_p          (fk_chg_p),
        .txbit_period      (txbit_period),
        .rxbit_period      (rxbit_period),
        .radio_fk          (radio_fk),
        .loadfreq_p        (loadfreq_p),
        .pll_en            (pll_en),
        .pll_locked        (pll_locked),
        .pa_en             (pa_en),
        .lna_en            (lna_en),
        .late_p            (late_p)
    );

    always #83 clk_6M = ~clk_6M;

    // 1 us pulse: one cycle in every six
    initial begin
        int div;
        div   = 0;
        p_1us = 1'b0;
        forever begin
            @(negedge clk_6M);
            div   = (div == 5) ? 0 : div + 1;
            p_1us = (div == 5);
        end
    end

    always @(posedge clk_6M) begin
        n_us   <= n_us + (p_1us ? 1 : 0);
        last_p <= p_1us;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle channel change; returns at the first negedge after
    // the load edge.
    task automatic hop(input logic [6:0] fk, input logic [9:0] setup);
        @(negedge clk_6M);
        nxtfk             = fk;
        regi_pllsetuptime = setup;
        fk_chg_p          = 1'b1;
        @(negedge clk_6M);
        fk_chg_p          = 1'b0;
    endtask

    // Wait for pll_locked; reports pulses and cycles elapsed since the call.
    task automatic wait_lock(output int pulses, output int cycles, output int lates);
        int start;
        start  = n_us;
        cycles = 0;
        lates  = 0;
        while (pll_locked !== 1'b1 && cycles < 8000) begin
            @(negedge clk_6M);
            cycles++;
            if (late_p === 1'b1) lates++;
        end
        if (cycles >= 8000) chk("lock_timeout", 32'd0, 32'd1);
        pulses = n_us - start;
    endtask

    task automatic wait_us(input int us);
        int start;
        start = n_us;
        while (n_us < start + us) @(negedge clk_6M);
    endtask

    initial begin
        int pulses, cycles, lates, bad, cnt;
        logic [6:0] fk_r;
        logic [9:0] st_r;

        rstz = 1'b0; fk_chg_p = 1'b0; txbit_period = 1'b0; rxbit_period = 1'b0;
        nxtfk = '0; regi_pllsetuptime = '0;
        repeat (3) @(negedge clk_6M);

        // ---- reset state
        chk("rst_radio_fk", 32'(radio_fk), 32'd0);
        chk("rst_pll_en", 32'(pll_en), 32'd0);
        chk("rst_pll_locked", 32'(pll_locked), 32'd0);
        chk("rst_pa_lna", 32'({pa_en, lna_en, loadfreq_p, late_p}), 32'd0);
        rstz = 1'b1;
        repeat (2) @(negedge clk_6M);

        // ---- first hop: channel 37, 150 us
        hop(7'd37, 10'd150);
        chk("hop1_loadfreq", 32'(loadfreq_p), 32'd1);
        chk("hop1_radio_fk", 32'(radio_fk), 32'd37);
        chk("hop1_pll_en", 32'(pll_en), 32'd1);
        chk("hop1_not_locked", 32'(pll_locked), 32'd0);
        @(negedge clk_6M);
        chk("hop1_loadfreq_once", 32'(loadfreq_p), 32'd0);
        wait_lock(pulses, cycles, lates);
        chk("hop1_settle_us", 32'(pulses), 32'd150);
        chk("hop1_settle_clk_window", 32'((cycles + 1 >= 894) && (cycles + 1 <= 906)), 32'd1);

        // ---- TX window of 366 us
        txbit_period = 1'b1;
        @(negedge clk_6M);
        chk("tx_pa_en", 32'(pa_en), 32'd1);
        bad = 0;
        cnt = n_us;
        while (n_us < cnt + 366) begin
            @(negedge clk_6M);
            if (pa_en !== 1'b1 || lna_en !== 1'b0) bad++;
        end
        chk("tx_hold_bad_cycles", 32'(bad), 32'd0);
        txbit_period = 1'b0;
        @(negedge clk_6M);
        chk("tx_pa_drop", 32'(pa_en), 32'd0);
        chk("tx_back_ready", 32'(pll_locked), 32'd1);
        chk("tx_radio_fk_kept", 32'(radio_fk), 32'd37);

        // ---- late RX request 20 us into a 150 us settle
        fk_r = 7'($urandom_range(0, 78));
        hop(fk_r, 10'd150);
        chk("hop2_radio_fk", 32'(radio_fk), 32'(fk_r));
        wait_us(20);
        rxbit_period = 1'b1;
        wait_lock(pulses, cycles, lates);
        chk("late_single_pulse", 32'(lates), 32'd1);
        chk("late_lna_at_lock", 32'(lna_en), 32'd0);
        @(negedge clk_6M);
        chk("late_lna_granted", 32'(lna_en), 32'd1);

        // ---- channel change during RX
        hop(7'd5, 10'd150);
        chk("rxhop_lna_drop", 32'(lna_en), 32'd0);
        chk("rxhop_loadfreq", 32'(loadfreq_p), 32'd1);
        chk("rxhop_radio_fk", 32'(radio_fk), 32'd5);
        wait_lock(pulses, cycles, lates);
        chk("rxhop_settle_us", 32'(pulses), 32'd150);
        rxbit_period = 1'b0;
        repeat (2) @(negedge clk_6M);

        // ---- both requests in READY: TX wins
        txbit_period = 1'b1;
        rxbit_period = 1'b1;
        @(negedge clk_6M);
        chk("both_pa_lna", 32'({pa_en, lna_en}), 32'b10);
        txbit_period = 1'b0;
        rxbit_period = 1'b0;
        repeat (2) @(negedge clk_6M);

        // ---- random settle time
        fk_r = 7'($urandom_range(0, 78));
        st_r = 10'($urandom_range(1, 40));
        hop(fk_r, st_r);
        wait_lock(pulses, cycles, lates);
        chk("rand_settle_us", 32'(pulses), 32'(st_r));
        chk("rand_radio_fk", 32'(radio_fk), 32'(fk_r));

        // ---- zero settle time, then idle power-down
        hop(7'd60, 10'd0);
        chk("zero_settle_in_settle", 32'({pll_en, pll_locked}), 32'b10);
        @(negedge clk_6M);
        chk("zero_settle_locked", 32'(pll_locked), 32'd1);
        cnt = n_us;
        cycles = 0;
        while (pll_en === 1'b1 && cycles < 2000) begin
            @(negedge clk_6M);
            cycles++;
        end
        chk("idle_us_count", 32'(n_us - cnt), 32'd100);
        chk("idle_fell_on_pulse", 32'(last_p), 32'd1);
        chk("idle_unlocked", 32'(pll_locked), 32'd0);

        // ---- request while IDLE: one late pulse, stays down
        txbit_period = 1'b1;
        lates = 0;
        bad = 0;
        repeat (12) begin
            @(negedge clk_6M);
            if (late_p === 1'b1) lates++;
            if (pll_en !== 1'b0 || pa_en !== 1'b0) bad++;
        end
        chk("idle_late_single", 32'(lates), 32'd1);
        chk("idle_stays_down", 32'(bad), 32'd0);
        txbit_period = 1'b0;

        // ---- asynchronous reset mid-TX
        st_r = 10'($urandom_range(1, 10));
        hop(7'($urandom_range(0, 78)), st_r);
        wait_lock(pulses, cycles, lates);
        txbit_period = 1'b1;
        @(negedge clk_6M);
        chk("rst_tx_pa_on", 32'(pa_en), 32'd1);
        #20 rstz = 1'b0;
        #1;
        chk("async_rst_pa", 32'(pa_en), 32'd0);
        chk("async_rst_fk_en", 32'({radio_fk, pll_en, pll_locked}), 32'd0);
        txbit_period = 1'b0;
        @(negedge clk_6M);
        rstz = 1'b1;
        repeat (2) @(negedge clk_6M);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_radio_pll_seq
`default_nettype wire
